memory_interface_arbiter: RTL

- Shares one single-port 32-bit word memory between the phoeniX instruction fetch interface and the data memory interface.
- Each requester issues one transaction at a time. The arbiter grants one transaction, runs a ready-handshaked access on the downstream memory, and returns read data with a one-cycle completion pulse.
- Data side has priority. An optional starvation guard bounds the fetch wait, and a timeout aborts accesses the memory never acknowledges.

---
 rtl/memory_interface_arbiter_pkg.sv | 26 ++
 rtl/memory_arbiter_wait_counter.sv | 42 ++++
 rtl/memory_interface_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_interface_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_interface_arbiter_pkg
// Description : Shared encodings for the instruction/data memory arbiter:
//               READ/WRITE access codes, ENABLE/DISABLE levels and the
//               arbiter FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_interface_arbiter_pkg;

    // Access direction, identical to the core's encoding
    localparam logic c_READ    = 1'b0;
    localparam logic c_WRITE   = 1'b1;

    // Generic enable levels
    localparam logic c_ENABLE  = 1'b1;
    localparam logic c_DISABLE = 1'b0;

    // Arbiter FSM states
    localparam int unsigned c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_IDLE         = 2'd0;
    localparam logic [c_STATE_W-1:0] c_INSTR_ACCESS = 2'd1;
    localparam logic [c_STATE_W-1:0] c_DATA_ACCESS  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_wait_counter
// Description : Saturating up-counter with synchronous clear. Counts from 0
//               up to TERMINAL and holds there; o_terminal is high while the
//               count equals TERMINAL.
// Ports       : clk         - system clock
//               reset       - synchronous, active-low reset
//               i_clear     - return the count to 0 (wins over increment)
//               i_increment - advance the count by one (saturating)
//               o_terminal  - count has reached TERMINAL
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter_wait_counter #(
    parameter int TERMINAL = 255,
    parameter int WIDTH    = (TERMINAL < 1) ? 1 : $clog2(TERMINAL + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_increment,
    output logic o_terminal
);

    localparam logic [WIDTH-1:0] c_TERMINAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_increment && (r_count != c_TERMINAL)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/memory_interface_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_interface_arbiter
// Description : Shares one single-port 32-bit word memory between the
//               instruction fetch and data memory interfaces. Data requests
//               have priority; an access the memory never acknowledges is
//               aborted after TIMEOUT_CYCLES with an error pulse.
//               Optional macro MEMORY_ARBITER_STARVATION_GUARD_EN forces a
//               fetch grant after MAX_WAIT consecutive data grants made while
//               fetch was waiting.
// Ports       : clk, reset (sync, active-low)
//               instruction_* / data_* - requester sides (enable, state,
//                                        address, frame_mask, write_data in;
//                                        read_data, ready, error out)
//               memory_*               - downstream memory side
// Revision    : 1.0 - initial release
// ============================================================================
module memory_interface_arbiter
    import memory_interface_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_WAIT       = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        instruction_enable,
    input  logic        instruction_state,
    input  logic [31:0] instruction_address,
    input  logic [3:0]  instruction_frame_mask,
    input  logic [31:0] instruction_write_data,
    output logic [31:0] instruction_read_data,
    output logic        instruction_ready,
    output logic        instruction_error,

    input  logic        data_enable,
    input  logic        data_state,
    input  logic [31:0] data_address,
    input  logic [3:0]  data_frame_mask,
    input  logic [31:0] data_write_data,
    output logic [31:0] data_read_data,
    output logic        data_ready,
    output logic        data_error,

    output logic        memory_enable,
    output logic        memory_state,
    output logic [31:0] memory_address,
    output logic [3:0]  memory_frame_mask,
    output logic [31:0] memory_write_data,
    input  logic [31:0] memory_read_data,
    input  logic        memory_ready
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;

    logic        w_grant_data;
    logic        w_grant_instr;
    logic        w_complete;
    logic        w_timeout;
    logic        w_timeout_tc;
    logic        w_force_instr;
    logic        w_in_access;

    logic [31:0] r_instruction_read_data;
    logic        r_instruction_ready;
    logic        r_instruction_error;
    logic [31:0] r_data_read_data;
    logic        r_data_ready;
    logic        r_data_error;
    logic        r_memory_enable;
    logic        r_memory_state;
    logic [31:0] r_memory_address;
    logic [3:0]  r_memory_frame_mask;
    logic [31:0] r_memory_write_data;

    assign w_in_access = (r_state != c_IDLE);

    // ------------------------------------------------------------------------
    // Access timeout: terminal at TIMEOUT_CYCLES-1 so that the abort lands on
    // the edge closing the TIMEOUT_CYCLES-th cycle of memory_enable high.
    // ------------------------------------------------------------------------
    memory_arbiter_wait_counter #(
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout_counter (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (!w_in_access || w_complete || w_timeout),
        .i_increment (w_in_access && !memory_ready),
        .o_terminal  (w_timeout_tc)
    );

`ifdef MEMORY_ARBITER_STARVATION_GUARD_EN
    logic w_starve_tc;

    // Counts data grants that bypassed a waiting fetch; a fetch grant or an
    // idle cycle with no fetch pending restarts the count.
    memory_arbiter_wait_counter #(
        .TERMINAL (MAX_WAIT)
    ) u_starvation_counter (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_grant_instr || ((r_state == c_IDLE) && !instruction_enable)),
        .i_increment (w_grant_data && instruction_enable),
        .o_terminal  (w_starve_tc)
    );

    assign w_force_instr = w_starve_tc && instruction_enable;
`else
    logic w_unused_max_wait;

    assign w_unused_max_wait = (MAX_WAIT != 0);
    assign w_force_instr     = c_DISABLE;
`endif

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_grant_data  = 1'b0;
        w_grant_instr = 1'b0;
        w_complete    = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (data_enable && !w_force_instr) begin
                    w_grant_data = 1'b1;
                    w_next_state = c_DATA_ACCESS;
                end else if (instruction_enable) begin
                    w_grant_instr = 1'b1;
                    w_next_state  = c_INSTR_ACCESS;
                end
            end
            c_INSTR_ACCESS, c_DATA_ACCESS: begin
                if (memory_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = c_IDLE;
                end else if (w_timeout_tc) begin
                    w_timeout    = 1'b1;
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latching and response registers. ready/error are single-cycle
    // pulses; the memory_* request fields stay at their last value after
    // completion since memory_enable alone qualifies them.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instruction_read_data <= '0;
            r_instruction_ready     <= 1'b0;
            r_instruction_error     <= 1'b0;
            r_data_read_data        <= '0;
            r_data_ready            <= 1'b0;
            r_data_error            <= 1'b0;
            r_memory_enable         <= c_DISABLE;
            r_memory_state          <= c_READ;
            r_memory_address        <= '0;
            r_memory_frame_mask     <= '0;
            r_memory_write_data     <= '0;
        end else begin
            r_instruction_ready <= 1'b0;
            r_instruction_error <= 1'b0;
            r_data_ready        <= 1'b0;
            r_data_error        <= 1'b0;

            if (w_grant_data) begin
                r_memory_enable     <= c_ENABLE;
                r_memory_state      <= data_state;
                r_memory_address    <= data_address;
                r_memory_frame_mask <= data_frame_mask;
                r_memory_write_data <= data_write_data;
            end else if (w_grant_instr) begin
                r_memory_enable     <= c_ENABLE;
                r_memory_state      <= instruction_state;
                r_memory_address    <= instruction_address;
                r_memory_frame_mask <= instruction_frame_mask;
                r_memory_write_data <= instruction_write_data;
            end

            if (w_complete || w_timeout) begin
                r_memory_enable <= c_DISABLE;
                if (r_state == c_DATA_ACCESS) begin
                    r_data_ready <= 1'b1;
                    r_data_error <= w_timeout;
                    if (w_complete) begin
                        r_data_read_data <= memory_read_data;
                    end
                end else begin
                    r_instruction_ready <= 1'b1;
                    r_instruction_error <= w_timeout;
                    if (w_complete) begin
                        r_instruction_read_data <= memory_read_data;
                    end
                end
            end
        end
    end

    assign instruction_read_data = r_instruction_read_data;
    assign instruction_ready     = r_instruction_ready;
    assign instruction_error     = r_instruction_error;
    assign data_read_data        = r_data_read_data;
    assign data_ready            = r_data_ready;
    assign data_error            = r_data_error;
    assign memory_enable         = r_memory_enable;
    assign memory_state          = r_memory_state;
    assign memory_address        = r_memory_address;
    assign memory_frame_mask     = r_memory_frame_mask;
    assign memory_write_data     = r_memory_write_data;

endmodule
`default_nettype wire
